// File: rtl/alu_result_capture_pkg.sv
// Shared constants for the accumulator computer's result-capture path.
// Build option: CAPTURE_DEDUP_EN (see alu_result_capture.sv).
package alu_result_capture_pkg;

  localparam int unsigned CAP_DATA_W = 4;
  localparam int unsigned CAP_DEPTH  = 8;
  localparam int unsigned CAP_DROP_W = 8;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/alu_result_capture_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered pointers and level.
// Caller only pushes when there is room (or a pop frees a slot) and only pops when non-empty.
module sync_fifo
  import alu_result_capture_pkg::*;
#(
  parameter int unsigned DATA_W = CAP_DATA_W,
  parameter int unsigned DEPTH  = CAP_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [level_w(DEPTH)-1:0]  level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_result_capture.sv
// Captures strobed ALU results into a FIFO drained over valid/ready; overflow is counted.
// Build option: define CAPTURE_DEDUP_EN to suppress captures repeating the last stored value.
module alu_result_capture
  import alu_result_capture_pkg::*;
#(
  parameter int unsigned DATA_W = CAP_DATA_W,
  parameter int unsigned DEPTH  = CAP_DEPTH,
  parameter int unsigned DROP_W = CAP_DROP_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          alu_out,
  input  logic                       cap_en,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [level_w(DEPTH)-1:0]  level,
  output logic                       full,
  output logic                       empty,
  output logic [DROP_W-1:0]          drop_cnt
);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  logic              pop, push, drop, dup, qual;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

`ifdef CAPTURE_DEDUP_EN
  logic [DATA_W-1:0] last_val_q;
  logic              last_vld_q;

  assign dup = last_vld_q && (alu_out == last_val_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_vld_q <= 1'b0;
    else if (push) last_vld_q <= 1'b1;
  end

  // Only accepted pushes refresh the reference; dropped samples leave it alone.
  always_ff @(posedge clk) begin
    if (push) last_val_q <= alu_out;
  end
`else
  assign dup = 1'b0;
`endif

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign qual      = cap_en & ~dup;
  // A simultaneous pop frees the slot, so a full FIFO can still accept.
  assign push      = qual & (~full | pop);
  assign drop      = qual & full & ~pop;

  always_comb begin
    drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (alu_out),
    .rdata_o (out_data),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: doc/alu_result_capture.md
Name: alu_result_capture

Overview:
- Downstream stage of the 4-bit accumulator computer: consumes the ALU result bus and buffers selected results in a FIFO for an external consumer (display driver, logger, bench monitor).
- Capture is qualified by a strobe, normally register-A-load OR register-B-load from the instruction word, so only results actually written back are recorded.
- Drains over a valid/ready handshake; overflows are dropped and counted.

Parameters:
- DATA_W, 4, width of ALU result captured.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- DROP_W, 8, width of saturating drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_out  input  DATA_W  ALU result bus from the computer.
- cap_en  input  1  capture strobe; sample alu_out at this rising edge.
- out_data  output  DATA_W  head-of-FIFO value.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  consumer accepts out_data this cycle.
- level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- drop_cnt  output  DROP_W  count of captures discarded due to full.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, level=0, drop_cnt=0, out_valid=0, out_data=0, empty=1, full=0. Storage contents not reset. Reset mid-transfer discards all entries; no partial state survives.
- pop = out_valid & out_ready. push = cap_en & (~full | pop).
- First-word-fall-through: out_data = mem[rd_ptr] whenever level>0; out_valid = ~empty. Capture-to-out_valid latency 1 cycle (sample at edge N, visible after edge N).
- Registered state: level, pointers, drop_cnt; full/empty/out_valid derived combinationally from level.
- Pointers wrap modulo DEPTH; level updates +1 push-only, -1 pop-only, unchanged push+pop.
- Empty + push + out_ready: no bypass; entry stored, popped at earliest next cycle.
- Full + cap_en + pop same cycle: push accepted (space freed), level stays DEPTH, no drop.
- Full + cap_en + no pop: sample discarded; drop_cnt increments, saturating at 2^DROP_W-1.
- out_ready while empty: no effect.
- out_data stable while out_valid=1 and out_ready=0.
- alu_out not checked for X when cap_en=0.

Optional Feature:
- Macro CAPTURE_DEDUP_EN.
- Defined: internal last_val register plus last_vld flag (reset 0). cap_en with last_vld=1 and alu_out==last_val is suppressed: no push, no drop count. Every accepted push updates last_val and sets last_vld. Dropped samples do not update last_val.
- Undefined: every qualified cap_en pushes; no extra registers.

Decomposition:
- computer_pkg: DATA_W default constant (4), default FIFO depth, drop-counter width, shared with the computer top-level.
- Sub-module sync_fifo (storage, pointers, level, full/empty); alu_result_capture wraps it with capture qualification, drop counter and the dedup option.

Test Plan:
- Reset: rst_n=0 mid-run with level=3 -> immediately level=0, out_valid=0, out_data=0, drop_cnt=0.
- Single capture: alu_out=4'hA, cap_en=1 for one cycle, out_ready=0 -> next cycle out_valid=1, out_data=A, level=1; hold 5 cycles, stable; out_ready=1 one cycle -> empty=1.
- Ordering/wrap: push 1..8, pop 4, push 9..C, drain -> outputs 1..C in order, full asserted after 8th push.
- Overflow: fill 8 entries, 3 more captures with out_ready=0 -> level=8, drop_cnt=3, drained data 1..8 unchanged.
- Full with simultaneous push/pop: level=8, cap_en=1 (alu_out=F), out_ready=1 -> level stays 8, drop_cnt unchanged, F is last entry drained.
- CAPTURE_DEDUP_EN: captures 3,3,3,5,5,3 -> FIFO holds 3,5,3; without macro holds all six.
